seq_divider: RTL

Multi-cycle, parametrised integer divider, the successor to the combinational `divider` in the ARM datapath. It computes quotient and remainder, signed or unsigned, one quotient bit per clock using radix-2 restoring division. It uses a start/done handshake, so the control unit stalls the pipeline on SDIV/UDIV instead of closing timing on a single-cycle 32-bit divide.

---
 rtl/seq_divider.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider (signed/unsigned) with a start/done handshake.
// Define SEQ_DIVIDER_EARLY_OUT_EN to let b==0 and |a|<|b| bypass the iteration loop.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] aOrig_q, aOrig_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;

  logic             signedOp;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   remShift, diff;
  logic             earlyOut;

  assign signedOp = ~op;
  assign magA     = (signedOp && a[WIDTH-1]) ? -a : a;
  assign magB     = (signedOp && b[WIDTH-1]) ? -b : b;
  // The dividend MSB shifts into the partial remainder; the quotient bit fills the vacated LSB.
  assign remShift = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = remShift - {1'b0, dvs_q};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign earlyOut = (b == '0) || (magA < magB);
`else
  assign earlyOut = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      aOrig_q  <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      quot_q   <= '0;
      remOut_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      aOrig_q  <= aOrig_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      quot_q   <= quot_d;
      remOut_q <= remOut_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    aOrig_d  = aOrig_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    quot_d   = quot_q;
    remOut_d = remOut_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          aOrig_d = a;
          dvs_d   = magB;
          zero_d  = (b == '0);
          negQ_d  = signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
          negR_d  = signedOp & a[WIDTH-1];
          cnt_d   = CW'(WIDTH - 1);
          // Early-out preloads a zero quotient and |a| as remainder so FIN needs no special path.
          if (earlyOut) begin
            rem_d   = magA;
            dvd_d   = '0;
            state_d = FIN;
          end else begin
            rem_d   = '0;
            dvd_d   = magA;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = remShift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        dz_d    = zero_q;
        state_d = IDLE;
        if (zero_q) begin
          quot_d   = '0;
          remOut_d = aOrig_q;
        end else begin
          quot_d   = negQ_q ? -dvd_q : dvd_q;
          remOut_d = negR_q ? -rem_q : rem_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dz_q;

endmodule
